load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, state enumeration and request payload for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 2;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 3;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    DONE  = 2'b11
  } lsu_state_e;

  // Core request as captured on acceptance.
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store_data;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              oReadEnable;
  logic              oWriteEnable;
  logic [BE_W-1:0]   oByteEnable;
  logic [ADDR_W-1:0] oAddress;
  logic [DATA_W-1:0] oWriteData;
  logic [DATA_W-1:0] iReadData;

  modport master (
    output oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData,
    input  iReadData
  );

  modport slave (
    input  oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData,
    output iReadData
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [BE_W-1:0]   byte_enable,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  logic [DATA_W-1:0] shifted;

  // Decode lanes by size and low address bits.
  always_comb begin
    shifted     = read_data >> {addr_lo, 3'b000};
    byte_enable = '0;
    write_data  = store_data;
    load_data   = read_data;
    misaligned  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_enable = 4'b0001 << addr_lo;
        write_data  = {4{store_data[7:0]}};
        load_data   = is_unsigned ? {24'h000000, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misaligned  = addr_lo[0];
        byte_enable = 4'b0011 << addr_lo;
        write_data  = {2{store_data[15:0]}};
        load_data   = is_unsigned ? {16'h0000, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        misaligned  = |addr_lo;
        byte_enable = 4'b1111;
      end
      default: begin
        misaligned  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time and runs it on a simple memory bus.
module load_store_unit
  import lsu_pkg::*;
#(
  // Bus cycles from address valid to read data valid (READ_LATENCY_MIN..READ_LATENCY_MAX).
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iReq,
  input  logic              iWrite,
  input  logic [1:0]        iSize,
  input  logic              iUnsigned,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iStoreData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oMisaligned,
  output logic [DATA_W-1:0] oLoadData,
  load_store_unit_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY);

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d, in_req, cur_req;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, mis_q, mis_d;
  logic              re_q, re_d, we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d, load_q, load_d;
  logic              accept_c;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wd, al_load;
  logic              al_mis;

  assign in_req   = '{write: iWrite, size: iSize, is_unsigned: iUnsigned,
                      addr: iAddr, store_data: iStoreData};
  assign accept_c = iReq && ((state_q == IDLE) || (state_q == DONE));
  // Lane logic sees the incoming request on the accepting edge, the captured one otherwise.
  assign cur_req  = accept_c ? in_req : req_q;

  lsu_align u_align (
    .size        (cur_req.size),
    .addr_lo     (cur_req.addr[1:0]),
    .is_unsigned (cur_req.is_unsigned),
    .store_data  (cur_req.store_data),
    .read_data   (bus.iReadData),
    .byte_enable (al_be),
    .write_data  (al_wd),
    .load_data   (al_load),
    .misaligned  (al_mis)
  );

  // Next-state and next-output logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    be_d    = '0;
    addr_d  = '0;
    wd_d    = '0;
    load_d  = load_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          req_d = in_req;
          if (al_mis) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else if (cur_req.write) begin
            state_d = WRITE;
            we_d    = 1'b1;
            busy_d  = 1'b1;
            be_d    = al_be;
            addr_d  = {cur_req.addr[ADDR_W-1:2], 2'b00};
            wd_d    = al_wd;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
            busy_d  = 1'b1;
            be_d    = al_be;
            addr_d  = {cur_req.addr[ADDR_W-1:2], 2'b00};
            cnt_d   = '0;
          end
        end
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          load_d  = al_load;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          re_d   = 1'b1;
          busy_d = 1'b1;
          be_d   = be_q;
          addr_d = addr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request and output registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      re_q    <= re_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      load_q  <= load_d;
    end
  end

  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oMisaligned      = mis_q;
  assign oLoadData        = load_q;
  assign bus.oReadEnable  = re_q;
  assign bus.oWriteEnable = we_q;
  assign bus.oByteEnable  = be_q;
  assign bus.oAddress     = addr_q;
  assign bus.oWriteData   = wd_q;

endmodule
